// File: rtl/spram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spram_fifo_ctrl_if
// Purpose  : push/pop handshakes and d1spram port bundle for spram_fifo_ctrl;
//            almost_full exists only when SPFIFO_AFULL_EN is defined.
// Revision : 1.0
// ============================================================================
interface spram_fifo_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 32
) ();
  localparam int c_aw = $clog2(SIZE);
  localparam int c_cw = $clog2(SIZE + 3);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ram_wen;
  logic             ram_ren;
  logic [c_aw-1:0]  ram_waddr;
  logic [c_aw-1:0]  ram_raddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic [c_cw-1:0]  count;
`ifdef SPFIFO_AFULL_EN
  logic             almost_full;
`endif

  // Controller side
  modport slave (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data,
    output ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata,
    output count
`ifdef SPFIFO_AFULL_EN
    , output almost_full
`endif
  );

  // Producer / consumer / RAM side
  modport master (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data,
    input  ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata,
    input  count
`ifdef SPFIFO_AFULL_EN
    , input almost_full
`endif
  );
endinterface
`default_nettype wire

// File: rtl/spram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spram_fifo_ctrl
// Purpose  : FIFO controller for a 1-cycle-latency single-port RAM, with a
//            2-entry output queue; SPFIFO_AFULL_EN adds a registered almost_full.
// Revision : 1.0
// ============================================================================
module spram_fifo_ctrl #(
  parameter int WIDTH     = 16,
  parameter int SIZE      = 32,
  parameter int AFULL_THR = 28
) (
  input  logic              clk,
  input  logic              rst,
  spram_fifo_ctrl_if.slave  bus
);
  localparam int                c_aw   = $clog2(SIZE);
  localparam int                c_rcw  = $clog2(SIZE + 1);
  localparam int                c_cw   = $clog2(SIZE + 3);
  localparam logic [c_aw-1:0]   c_last = c_aw'(SIZE - 1);
  localparam logic [c_rcw-1:0]  c_full = c_rcw'(SIZE);

  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_rcw-1:0] r_ram_cnt;
  logic             r_rd_pend;
  logic [1:0]       r_oq_cnt;
  logic [WIDTH-1:0] r_oq0;
  logic [WIDTH-1:0] r_oq1;

  logic             w_pop;
  logic             w_fetch;
  logic             w_push;
  logic             w_room;
  logic [1:0]       w_oq_kept;

  // A prefetch is issued only if the OQ can still absorb it after this pop,
  // counting the word already in flight; the read always wins the port.
  always_comb begin
    w_pop     = (r_oq_cnt != 2'd0) && bus.out_ready;
    w_oq_kept = r_oq_cnt - {1'b0, w_pop};
    w_fetch   = (r_ram_cnt != '0) &&
                (({1'b0, w_oq_kept} + {2'b00, r_rd_pend}) < 3'd2);
    w_room    = (r_ram_cnt != c_full) && !w_fetch;
    w_push    = bus.in_valid && w_room;
  end

  assign bus.in_ready  = w_room;
  assign bus.out_valid = (r_oq_cnt != 2'd0);
  assign bus.out_data  = r_oq0;
  assign bus.ram_wen   = w_push;
  assign bus.ram_ren   = w_fetch;
  assign bus.ram_waddr = r_wptr;
  assign bus.ram_raddr = r_rptr;
  assign bus.ram_wdata = bus.in_data;
  assign bus.count     = c_cw'(r_ram_cnt) + c_cw'(r_oq_cnt) + c_cw'(r_rd_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_oq_cnt  <= 2'd0;
      r_oq0     <= '0;
      r_oq1     <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
      end
      if (w_fetch) begin
        r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
      end
      if (w_push) begin
        r_ram_cnt <= r_ram_cnt + 1'b1;
      end else if (w_fetch) begin
        r_ram_cnt <= r_ram_cnt - 1'b1;
      end
      r_rd_pend <= w_fetch;
      r_oq_cnt  <= w_oq_kept + {1'b0, r_rd_pend};
      // Head only shifts when a second entry exists, so an emptied OQ keeps
      // presenting the last word on out_data.
      if (w_pop && (r_oq_cnt == 2'd2)) begin
        r_oq0 <= r_oq1;
      end
      if (r_rd_pend) begin
        if (w_oq_kept == 2'd0) begin
          r_oq0 <= bus.ram_rdata;
        end else begin
          r_oq1 <= bus.ram_rdata;
        end
      end
    end
  end

`ifdef SPFIFO_AFULL_EN
  logic [c_cw-1:0] w_count_next;
  logic            r_afull;

  // Reads only move words between RAM, flight and OQ, so the total changes
  // by push and pop alone.
  assign w_count_next    = bus.count + c_cw'(w_push) - c_cw'(w_pop);
  assign bus.almost_full = r_afull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_afull <= 1'b0;
    end else begin
      r_afull <= (int'(w_count_next) >= AFULL_THR);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram_fifo_ctrl
// Purpose  : drives a SIZE=32 and a SIZE=5 controller with shared stimulus,
//            each backed by a RAM model and checked against a scoreboard.
// Revision : 1.0
// ============================================================================
module tb_spram_fifo_ctrl;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        af0;
  logic        af1;

  int n_checks = 0;
  int n_errors = 0;

  spram_fifo_ctrl_if #(.WIDTH(16), .SIZE(32)) if0 ();
  spram_fifo_ctrl_if #(.WIDTH(16), .SIZE(5))  if1 ();

  spram_fifo_ctrl #(.WIDTH(16), .SIZE(32), .AFULL_THR(28)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave));
  spram_fifo_ctrl #(.WIDTH(16), .SIZE(5),  .AFULL_THR(4))  u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave));

  assign if0.in_valid  = in_valid;
  assign if0.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_data   = in_data;
  assign if1.out_ready = out_ready;
`ifdef SPFIFO_AFULL_EN
  assign af0 = if0.almost_full;
  assign af1 = if1.almost_full;
`else
  assign af0 = 1'b0;
  assign af1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d1spram models: read data valid the cycle after ren
  logic [15:0] mem0 [0:31];
  logic [15:0] mem1 [0:7];
  always @(posedge clk) begin
    if (if0.ram_wen) mem0[if0.ram_waddr] <= if0.ram_wdata;
    if (if0.ram_ren) if0.ram_rdata <= mem0[if0.ram_raddr];
    if (if1.ram_wen) mem1[if1.ram_waddr] <= if1.ram_wdata;
    if (if1.ram_ren) if1.ram_rdata <= mem1[if1.ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: words accepted but not yet popped, in order, plus RAM
  // write/read tallies since reset.
  logic [15:0] sb [2][64];
  int          sb_wr [2];
  int          sb_rd [2];
  int          n_wr [2];
  int          n_rd [2];
  bit          p_ov [2];
  bit          p_ordy [2];
  logic [15:0] p_dout [2];

  task automatic mon(input int k, input bit wen, input bit ren, input bit iv, input bit ir,
                     input bit ov, input bit ordy, input bit af,
                     input int waddr, input int raddr, input int cnt,
                     input int size, input int thr,
                     input logic [15:0] wdata, input logic [15:0] din, input logic [15:0] dout);
    int occ;
    if (rst) begin
      sb_wr[k] = 0; sb_rd[k] = 0; n_wr[k] = 0; n_rd[k] = 0;
      p_ov[k] = 1'b0; p_ordy[k] = 1'b0; p_dout[k] = '0;
      return;
    end
    occ = sb_wr[k] - sb_rd[k];
    chk($sformatf("count%0d", k), cnt, occ);
    chk($sformatf("port_excl%0d", k), wen && ren, 0);
    chk($sformatf("wen_hs%0d", k), wen, iv && ir);
    chk($sformatf("ready_full%0d", k), ir && ((n_wr[k] - n_rd[k]) == size), 0);
    chk($sformatf("ren_empty%0d", k), ren && (n_wr[k] == n_rd[k]), 0);
    chk($sformatf("ov_empty%0d", k), ov && (occ == 0), 0);
`ifdef SPFIFO_AFULL_EN
    chk($sformatf("afull%0d", k), af, occ >= thr);
`endif
    if (p_ov[k] && !p_ordy[k]) begin
      chk($sformatf("hold_valid%0d", k), ov, 1);
      chk($sformatf("hold_data%0d", k), dout, p_dout[k]);
    end
    if (wen) begin
      chk($sformatf("waddr%0d", k), waddr, n_wr[k] % size);
      chk($sformatf("wdata%0d", k), wdata, din);
      sb[k][sb_wr[k] % 64] = din;
      sb_wr[k]++;
      n_wr[k]++;
    end
    if (ren) begin
      chk($sformatf("raddr%0d", k), raddr, n_rd[k] % size);
      n_rd[k]++;
    end
    if (ov && ordy && occ > 0) begin
      chk($sformatf("pop_data%0d", k), dout, sb[k][sb_rd[k] % 64]);
      sb_rd[k]++;
    end
    p_ov[k] = ov; p_ordy[k] = ordy; p_dout[k] = dout;
  endtask

  always @(negedge clk) begin
    mon(0, if0.ram_wen, if0.ram_ren, in_valid, if0.in_ready, if0.out_valid, out_ready, af0,
        int'(if0.ram_waddr), int'(if0.ram_raddr), int'(if0.count), 32, 28,
        if0.ram_wdata, in_data, if0.out_data);
    mon(1, if1.ram_wen, if1.ram_ren, in_valid, if1.in_ready, if1.out_valid, out_ready, af1,
        int'(if1.ram_waddr), int'(if1.ram_raddr), int'(if1.count), 5, 4,
        if1.ram_wdata, in_data, if1.out_data);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int cyc;
    int pushed;
    int popped;
    int burst;
    int got;

    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_in_ready", if0.in_ready, 1);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_out_data", if0.out_data, 0);
    chk("rst_wen", if0.ram_wen, 0);
    chk("rst_ren", if0.ram_ren, 0);
    chk("rst_addrs", {if0.ram_waddr, if0.ram_raddr}, 0);
    chk("rst_count", if0.count, 0);
    chk("rst_count1", if1.count, 0);
    next_cycle();
    rst = 1'b0;

    // Single word latency through an empty FIFO
    in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_wen0", if0.ram_wen, 1);
    chk("t1_waddr0", if0.ram_waddr, 0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_ren1", if0.ram_ren, 1);
    chk("t1_raddr1", if0.ram_raddr, 0);
    chk("t1_stall1", if0.in_ready, 0);
    next_cycle();
    @(negedge clk);
    chk("t1_ov2", if0.out_valid, 0);
    chk("t1_cnt2", if0.count, 1);
    next_cycle();
    @(negedge clk);
    chk("t1_ov3", if0.out_valid, 1);
    chk("t1_data3", if0.out_data, 16'hA5A5);
    next_cycle();
    @(negedge clk);
    chk("t1_cnt4", if0.count, 0);
    chk("t1_ov4", if0.out_valid, 0);
    chk("t1_hold4", if0.out_data, 16'hA5A5);
    next_cycle();

    // Fill to full with the consumer stalled, then drain at full rate
    do_reset();
    i = 0; cyc = 0;
    while (i < 34 && cyc < 100) begin
      in_valid = 1'b1; in_data = 16'(i);
      @(negedge clk);
      if (if0.in_ready) i++;
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t2_fill", i, 34);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t2_count", if0.count, 34);
    chk("t2_full", if0.in_ready, 0);
    chk("t2_head", if0.out_data, 0);
    next_cycle();
    out_ready = 1'b1;
    for (int j = 0; j < 34; j++) begin
      @(negedge clk);
      chk("t2_nogap", if0.out_valid, 1);
      chk("t2_order", if0.out_data, j);
      next_cycle();
    end
    @(negedge clk);
    chk("t2_empty", if0.out_valid, 0);
    chk("t2_cnt0", if0.count, 0);
    next_cycle();

    // Continuous then random push/pop traffic
    do_reset();
    pushed = 0;
    for (int j = 0; j < 100; j++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 16'($urandom);
      @(negedge clk);
      if (if0.in_ready) pushed++;
      next_cycle();
    end
    chk("t3_flow", pushed >= 30, 1);
    for (int j = 0; j < 300; j++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 16'($urandom);
      next_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) next_cycle();
    @(negedge clk);
    chk("t3_drain0", if0.count, 0);
    chk("t3_drain1", if1.count, 0);
    next_cycle();

    // Bursts of 3 through the SIZE=5 instance to exercise pointer wrap
    do_reset();
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 23 && cyc < 600) begin
      burst = ((23 - pushed) < 3) ? (23 - pushed) : 3;
      got = 0;
      out_ready = 1'b0;
      while (got < burst && cyc < 600) begin
        in_valid = 1'b1; in_data = 16'($urandom);
        @(negedge clk);
        if (if1.in_ready) got++;
        next_cycle();
        cyc++;
      end
      in_valid = 1'b0;
      pushed += got;
      out_ready = 1'b1;
      got = 0;
      while (got < burst && cyc < 600) begin
        @(negedge clk);
        if (if1.out_valid) got++;
        next_cycle();
        cyc++;
      end
      popped += got;
    end
    chk("t4_words", popped, 23);
    @(negedge clk);
    chk("t4_cnt", if1.count, 0);
    chk("t4_wptr", if1.ram_waddr, 23 % 5);
    chk("t4_rptr", if1.ram_raddr, 23 % 5);
    next_cycle();

    // Reset while a read is in flight
    do_reset();
    in_valid = 1'b1; in_data = 16'h1234;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_ren", if0.ram_ren, 1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ov", if0.out_valid, 0);
    chk("t5_cnt", if0.count, 0);
    next_cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_stale_v", if0.out_valid, 0);
      chk("t5_no_stale_d", if0.out_data, 0);
      chk("t5_cnt_after", if0.count, 0);
      next_cycle();
    end

`ifdef SPFIFO_AFULL_EN
    // almost_full around the threshold
    do_reset();
    i = 0; cyc = 0;
    while (i < 30 && cyc < 100) begin
      in_valid = 1'b1; in_data = 16'(i);
      @(negedge clk);
      if (if0.in_ready) i++;
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_cnt_hi", if0.count, 30);
    chk("t6_af_hi", af0, 1);
    next_cycle();
    out_ready = 1'b1;
    cyc = 0;
    while (if0.count > 26 && cyc < 20) begin
      next_cycle();
      cyc++;
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("t6_af_lo", af0, 0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
